zx_scandoubler: RTL and testbench
=================================

// Module: zx_scandoubler
// PURPOSE
//  Converts the ULA 15.6 kHz RGBI pixel stream to a 31.2 kHz VGA-style output for VGA monitors.
//  Sits directly downstream of the ULA video path. Each input line is written into one bank of
//  a two-bank line buffer at the 7 MHz pixel rate. The previous line is read from the other bank
//  at 14 MHz and output twice. Bypass mode passes the native stream through unchanged.
// PARAMETERS
//  H_TOTAL   448  input pixels per line; also output clocks per doubled half-line
//  HS_START  320  output pixel index where vga_hs asserts
//  HS_WIDTH  54   vga_hs low width, in clk14 cycles
//  AW        9    line-buffer address width; 2**AW >= H_TOTAL
// PORTS
//  clk14       in   1  14 MHz system clock; single clock domain
//  rst_n       in   1  synchronous reset, active low
//  pix_en      in   1  input pixel strobe; one clk14 in two (ULA pixel phase)
//  line_start  in   1  1-cycle pulse, coincident with pix_en of input pixel 0
//  vsync_in    in   1  input vertical sync level, active high
//  rgbi        in   4  input pixel {i,g,r,b}; already blanked upstream
//  csync_in    in   1  native composite sync, active low (bypass path)
//  bypass      in   1  1 = pass native signals through, 0 = scandoubled output
//  vga_rgbi    out  4  output pixel {i,g,r,b}, registered
//  vga_hs      out  1  output horizontal sync, active low, registered
//  vga_vs      out  1  output vertical sync, active low, registered
// BEHAVIOUR
//  Reset (rst_n=0 at a clk14 edge) sets:
//   - vga_rgbi=0, vga_hs=1, vga_vs=1
//   - wr_bank=0, wr_addr=0, rd_addr=0, pass=0, rd_valid=0, vs_line=0
//   - line-buffer contents are don't-care
//  Write side:
//   - On pix_en, store rgbi at [wr_bank][wr_addr], then wr_addr++.
//   - wr_addr saturates at H_TOTAL-1; an overlong line overwrites the last cell and never wraps.
//  line_start:
//   - wr_bank toggles; the current pixel is written at addr 0 of the new bank.
//   - wr_addr <= 1, rd_addr <= 0, pass <= 0.
//   - rd_valid <= 1; vs_line <= vsync_in sampled on this cycle.
//  Read side, every clk14:
//   - Read [~wr_bank][rd_addr], then rd_addr++.
//   - At rd_addr==H_TOTAL-1 with pass=0: rd_addr <= 0, pass <= 1.
//   - At rd_addr==H_TOTAL-1 with pass=1: rd_addr holds and output pixels are forced to 0 until
//     the next line_start.
//  Simultaneous line_start and read wrap: line_start wins.
//  Early line_start (short line): the read restarts immediately and the remaining pass is dropped.
//  rd_valid=0 (the first line after reset): output pixels are 0; sync is still generated.
//  Output latency, scandoubled: 2 clk14 from rd_addr to pins (registered RAM read + output register).
//  vga_hs = 0 while the delayed rd_addr is in [HS_START, HS_START+HS_WIDTH), in both passes.
//   Sync is aligned with its pixel data through the same 2-stage delay.
//  vga_vs = ~vs_line, i.e. one input line later than vsync_in. It changes only at line_start,
//   so vertical sync width is 2x the input count of output lines.
//  bypass=1:
//   - vga_rgbi <= rgbi when pix_en; vga_hs <= csync_in; vga_vs <= 1.
//   - Latency is 1 clk14. Write/read counters keep running.
//   - Toggling bypass may glitch one line, with no lockup.
//  Reset mid-line: all state clears; the first output appears after the second line_start.
// STRUCTURE
//  Shared header gains the ULA video timing constants (H_TOTAL=448, V_TOTAL=320) so that the
//   ULA and this block use one definition. The RGBI bit order {i,g,r,b} is also defined there.
//  Sub-module zx_linebuf:
//   - simple dual-port RAM, 2**(AW+1) x 4
//   - one write port, one registered read port; bank = MSB of address
//   - no reset; infers CPLD/FPGA block or distributed RAM
//  Top holds the write/read counters, bank and pass control, sync generation and output mux.
// TESTING
//  1. Reset: hold rst_n=0 for 4 clk14.
//     -> vga_rgbi=0, vga_hs=1, vga_vs=1; first line after release outputs all-zero pixels.
//  2. Doubling: line N pixel k = k[3:0], full 448-pixel line, then line_start.
//     -> output pixel k appears at cycles k+2 and k+450 after line_start; 896 output cycles/line.
//  3. Hsync: run 3 lines.
//     -> vga_hs low for exactly 54 cycles starting at output index 320+2, in both passes of
//        every line.
//  4. Vsync: vsync_in high over 8 input lines.
//     -> vga_vs low for 16 output half-lines, starting one input line late.
//  5. Short/long lines:
//     -> line_start after 300 pixels: pass 2 truncated, no stuck state.
//     -> 500-pixel line: addr 447 holds the last pixel, nothing is written to addr 0..51.
//  6. Bypass: set bypass=1 with a constant rgbi=4'b1010.
//     -> vga_rgbi=4'b1010 one cycle after pix_en; vga_hs tracks csync_in at 1-cycle latency;
//        vga_vs=1.

Source files
------------

// File: rtl/zx_scandoubler_pkg.sv
// Shared ULA video timing and RGBI definitions for the ULA and the VGA scandoubler.
// Keeping them in one place means both blocks agree on line length and pixel bit order.
package zx_scandoubler_pkg;

  localparam int H_TOTAL  = 448;
  localparam int V_TOTAL  = 320;
  localparam int HS_START = 320;
  localparam int HS_WIDTH = 54;
  localparam int AW       = 9;

  typedef logic [AW-1:0] addr_t;

  typedef struct packed {
    logic i;
    logic g;
    logic r;
    logic b;
  } rgbi_t;

  typedef enum logic [1:0] {
    RD_PASS1,
    RD_PASS2,
    RD_HOLD
  } rd_state_t;

  function automatic logic in_hsync(input addr_t addr);
    return (addr >= addr_t'(HS_START)) && (addr < addr_t'(HS_START + HS_WIDTH));
  endfunction

endpackage

// File: rtl/zx_scandoubler_if.sv
// Video bundle between the ULA video path and the scandoubler:
// native pixel stream and syncs in, VGA-rate pixel and syncs out.
interface zx_scandoubler_if;
  import zx_scandoubler_pkg::*;

  logic  pix_en;
  logic  line_start;
  logic  vsync_in;
  rgbi_t rgbi;
  logic  csync_in;
  logic  bypass;
  rgbi_t vga_rgbi;
  logic  vga_hs;
  logic  vga_vs;

  modport master (
    output pix_en, line_start, vsync_in, rgbi, csync_in, bypass,
    input  vga_rgbi, vga_hs, vga_vs
  );

  modport slave (
    input  pix_en, line_start, vsync_in, rgbi, csync_in, bypass,
    output vga_rgbi, vga_hs, vga_vs
  );

endinterface

// File: rtl/zx_linebuf.sv
// Two-bank line buffer: simple dual-port RAM with one write port and one registered read port.
// The bank is the address MSB; there is no reset so it maps onto block or distributed RAM.
module zx_linebuf
  import zx_scandoubler_pkg::*;
#(
  parameter int ADDR_W = AW + 1,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/zx_scandoubler.sv
// ULA 15.6 kHz RGBI to 31.2 kHz VGA scandoubler: each line is written at the pixel rate
// into one bank while the previous line is read twice from the other bank at clk14.
module zx_scandoubler
  import zx_scandoubler_pkg::*;
(
  input  logic                  clk14,
  input  logic                  rst_n,
  zx_scandoubler_if.slave       vid
);

  localparam addr_t LAST = addr_t'(H_TOTAL - 1);

  logic      wr_bank;
  addr_t     wr_addr;
  addr_t     rd_addr;
  logic      line_seen;
  logic      rd_valid;
  logic      vs_line;
  rd_state_t rd_state;
  rd_state_t rd_state_next;
  logic      rd_last;
  logic      rd_blank;
  logic      rd_restart;

  logic [AW:0] buf_wr_addr;
  logic [AW:0] buf_rd_addr;
  logic [3:0]  buf_q;

  addr_t addr_d1;
  logic  blank_d1;

  assign rd_last = (rd_addr == LAST);

  // line_start redirects the coincident pixel to cell 0 of the bank about to become current
  assign buf_wr_addr = vid.line_start ? {~wr_bank, addr_t'(0)} : {wr_bank, wr_addr};
  assign buf_rd_addr = {~wr_bank, rd_addr};

  zx_linebuf #(
    .ADDR_W (AW + 1),
    .DATA_W (4)
  ) u_linebuf (
    .clk     (clk14),
    .wr_en   (vid.pix_en),
    .wr_addr (buf_wr_addr),
    .wr_data (vid.rgbi),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_q)
  );

  always_ff @(posedge clk14) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
    end else if (vid.line_start) begin
      wr_bank <= ~wr_bank;
      wr_addr <= addr_t'(1);
    end else if (vid.pix_en && (wr_addr != LAST)) begin
      wr_addr <= wr_addr + addr_t'(1);
    end
  end

  // The line in progress at reset release is partial, so only the line after
  // the second line_start is trusted as display data.
  always_ff @(posedge clk14) begin
    if (!rst_n) begin
      line_seen <= 1'b0;
      rd_valid  <= 1'b0;
      vs_line   <= 1'b0;
    end else if (vid.line_start) begin
      line_seen <= 1'b1;
      rd_valid  <= line_seen;
      vs_line   <= vid.vsync_in;
    end
  end

  always_ff @(posedge clk14) begin
    if (!rst_n) begin
      rd_state <= RD_PASS1;
    end else begin
      rd_state <= rd_state_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state;
    if (vid.line_start) begin
      rd_state_next = RD_PASS1;
    end else begin
      case (rd_state)
        RD_PASS1: if (rd_last) rd_state_next = RD_PASS2;
        RD_PASS2: if (rd_last) rd_state_next = RD_HOLD;
        RD_HOLD:  rd_state_next = RD_HOLD;
        default:  rd_state_next = RD_PASS1;
      endcase
    end
  end

  always_comb begin
    rd_blank   = 1'b0;
    rd_restart = 1'b0;
    if (!rd_valid || (rd_state == RD_HOLD)) begin
      rd_blank = 1'b1;
    end
    if (vid.line_start || (rd_last && (rd_state == RD_PASS1))) begin
      rd_restart = 1'b1;
    end
  end

  always_ff @(posedge clk14) begin
    if (!rst_n) begin
      rd_addr <= '0;
    end else if (rd_restart) begin
      rd_addr <= '0;
    end else if (!rd_last) begin
      rd_addr <= rd_addr + addr_t'(1);
    end
  end

  // Address and blank ride alongside the RAM read so sync stays aligned with its pixel
  always_ff @(posedge clk14) begin
    if (!rst_n) begin
      addr_d1  <= '0;
      blank_d1 <= 1'b1;
    end else begin
      addr_d1  <= rd_addr;
      blank_d1 <= rd_blank;
    end
  end

  always_ff @(posedge clk14) begin
    if (!rst_n) begin
      vid.vga_rgbi <= '0;
      vid.vga_hs   <= 1'b1;
      vid.vga_vs   <= 1'b1;
    end else if (vid.bypass) begin
      if (vid.pix_en) begin
        vid.vga_rgbi <= vid.rgbi;
      end
      vid.vga_hs <= vid.csync_in;
      vid.vga_vs <= 1'b1;
    end else begin
      vid.vga_rgbi <= blank_d1 ? rgbi_t'(4'b0000) : rgbi_t'(buf_q);
      vid.vga_hs   <= ~in_hsync(addr_d1);
      vid.vga_vs   <= ~vs_line;
    end
  end

endmodule

// File: tb/tb_zx_scandoubler.sv
// Scoreboard bench for zx_scandoubler: a line-level reference model predicts every
// output cycle, and a negedge checker compares the DUT pins against the queued values.
module tb_zx_scandoubler;
  import zx_scandoubler_pkg::*;

  logic clk14 = 1'b0;
  logic rst_n = 1'b0;

  zx_scandoubler_if vid();

  zx_scandoubler dut (
    .clk14 (clk14),
    .rst_n (rst_n),
    .vid   (vid)
  );

  always #5 clk14 = ~clk14;

  typedef struct {
    int         target;
    logic [3:0] rgbi;
    logic       hs;
  } pix_exp_t;

  typedef struct {
    int   target;
    logic vs;
  } vs_exp_t;

  pix_exp_t pix_q[$];
  vs_exp_t  vs_q[$];

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  logic [3:0] mem_m [2][H_TOTAL];
  logic       wbank;
  int         waddr;
  int         ls_edge;
  int         ls_cnt;
  logic       vsl;
  logic       byp_prev;
  logic [3:0] byp_pix;
  int         settle;
  int         j;
  int         idx;
  logic [3:0] p_exp;
  logic       h_exp;

  task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk14);
    #1;
  endtask

  task automatic idle(input int n);
    vid.pix_en     = 1'b0;
    vid.line_start = 1'b0;
    for (int c = 0; c < n; c++) begin
      tick();
    end
  endtask

  // One input line: pixel k on even cycles, a different value on odd cycles
  task automatic applyStimulus(input int npix, input logic vs, input logic byp,
                               input int seed, input logic const_pix);
    logic [3:0] val;
    for (int c = 0; c < 2 * npix; c++) begin
      val = 4'((c / 2) + seed + ((c / 2) >> 4));
      vid.line_start = (c == 0);
      vid.pix_en     = ((c % 2) == 0);
      vid.rgbi       = const_pix ? 4'b1010 : (((c % 2) == 0) ? val : ~val);
      vid.vsync_in   = vs;
      vid.bypass     = byp;
      vid.csync_in   = ((c % 7) != 3);
      tick();
    end
  endtask

  // Reference model: outputs are derived from cycles elapsed since the last line_start
  always @(posedge clk14) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      wbank    = 1'b0;
      waddr    = 0;
      ls_edge  = cyc;
      ls_cnt   = 0;
      vsl      = 1'b0;
      settle   = 2;
      byp_prev = vid.bypass;
      pix_q.delete();
      vs_q.delete();
    end else begin
      if (vid.bypass !== byp_prev) begin
        byp_prev = vid.bypass;
        settle   = 2;
        while (pix_q.size() > 0 && pix_q[$].target >= cyc) void'(pix_q.pop_back());
        while (vs_q.size() > 0 && vs_q[$].target >= cyc) void'(vs_q.pop_back());
      end
      if (vid.line_start) begin
        wbank   = ~wbank;
        waddr   = 0;
        ls_edge = cyc;
        ls_cnt++;
        vsl     = vid.vsync_in;
      end
      if (vid.pix_en) begin
        mem_m[wbank][waddr] = vid.rgbi;
        if (waddr < H_TOTAL - 1) waddr++;
      end
      if (vid.bypass && vid.pix_en) byp_pix = vid.rgbi;

      if (settle > 0) begin
        settle--;
      end else if (vid.bypass) begin
        pix_q.push_back('{cyc, byp_pix, vid.csync_in});
        vs_q.push_back('{cyc, 1'b1});
      end else begin
        j = cyc - ls_edge;
        if (j < 2 * H_TOTAL) begin
          idx   = j % H_TOTAL;
          h_exp = !((idx >= HS_START) && (idx < HS_START + HS_WIDTH));
          p_exp = (ls_cnt >= 2) ? mem_m[~wbank][idx] : 4'b0000;
        end else begin
          h_exp = 1'b1;
          p_exp = 4'b0000;
        end
        pix_q.push_back('{cyc + 2, p_exp, h_exp});
        vs_q.push_back('{cyc + 1, ~vsl});
      end
    end
  end

  always @(negedge clk14) begin
    pix_exp_t pe;
    vs_exp_t  ve;
    if (rst_n) begin
      while (pix_q.size() > 0 && pix_q[0].target < cyc) void'(pix_q.pop_front());
      while (vs_q.size() > 0 && vs_q[0].target < cyc) void'(vs_q.pop_front());
      if (pix_q.size() > 0 && pix_q[0].target == cyc) begin
        pe = pix_q.pop_front();
        checkOutput("rgbi", vid.vga_rgbi, pe.rgbi);
        checkOutput("hs", {3'b000, vid.vga_hs}, {3'b000, pe.hs});
      end
      if (vs_q.size() > 0 && vs_q[0].target == cyc) begin
        ve = vs_q.pop_front();
        checkOutput("vs", {3'b000, vid.vga_vs}, {3'b000, ve.vs});
      end
    end
  end

  initial begin
    vid.pix_en     = 1'b0;
    vid.line_start = 1'b0;
    vid.vsync_in   = 1'b0;
    vid.rgbi       = 4'b0000;
    vid.csync_in   = 1'b1;
    vid.bypass     = 1'b0;
    rst_n          = 1'b0;

    for (int r = 0; r < 4; r++) begin
      @(posedge clk14);
      @(negedge clk14);
      checkOutput("rst_rgbi", vid.vga_rgbi, 4'b0000);
      checkOutput("rst_hs", {3'b000, vid.vga_hs}, 4'b0001);
      checkOutput("rst_vs", {3'b000, vid.vga_vs}, 4'b0001);
    end
    tick();
    rst_n = 1'b1;
    $display("[TB] reset released");

    idle(10);
    applyStimulus(448, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(448, 1'b0, 1'b0, 3, 1'b0);
    applyStimulus(448, 1'b0, 1'b0, 5, 1'b0);
    for (int l = 0; l < 8; l++) begin
      applyStimulus(448, 1'b1, 1'b0, l, 1'b0);
    end
    applyStimulus(448, 1'b0, 1'b0, 7, 1'b0);
    applyStimulus(448, 1'b0, 1'b0, 12, 1'b0);

    $display("[TB] short and long lines");
    applyStimulus(300, 1'b0, 1'b0, 9, 1'b0);
    applyStimulus(448, 1'b0, 1'b0, 2, 1'b0);
    applyStimulus(500, 1'b0, 1'b0, 11, 1'b0);
    applyStimulus(448, 1'b0, 1'b0, 4, 1'b0);
    applyStimulus(448, 1'b0, 1'b0, 6, 1'b0);

    $display("[TB] bypass");
    applyStimulus(448, 1'b0, 1'b1, 0, 1'b1);
    applyStimulus(448, 1'b0, 1'b1, 0, 1'b1);
    applyStimulus(448, 1'b0, 1'b0, 1, 1'b0);
    applyStimulus(448, 1'b0, 1'b0, 13, 1'b0);

    $display("[TB] mid-line reset");
    applyStimulus(200, 1'b0, 1'b0, 8, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk14);
    checkOutput("midrst_rgbi", vid.vga_rgbi, 4'b0000);
    checkOutput("midrst_hs", {3'b000, vid.vga_hs}, 4'b0001);
    checkOutput("midrst_vs", {3'b000, vid.vga_vs}, 4'b0001);
    tick();
    rst_n = 1'b1;
    idle(5);
    applyStimulus(448, 1'b0, 1'b0, 10, 1'b0);
    applyStimulus(448, 1'b1, 1'b0, 14, 1'b0);
    applyStimulus(448, 1'b0, 1'b0, 15, 1'b0);
    idle(1000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
